// File: rtl/id_ex_alu_issue_if.sv
// ID -> issue -> EX bundle: instruction handshake on the ID side, ALU operands plus side info on the EX side.
interface id_ex_alu_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_DA;
  logic [31:0] ALU_DB;
  logic [3:0]  ALU_CTL;
  logic [2:0]  out_kind;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;
  logic [31:0] out_store_data;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  // master: the ID/EX environment around the stage; slave: the issue stage itself
  modport master (
    output flush, in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, ALU_DA, ALU_DB, ALU_CTL, out_kind, out_funct3,
           out_imm, out_store_data, out_pc, out_rd, out_rd_we, out_illegal
  );
  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, ALU_DA, ALU_DB, ALU_CTL, out_kind, out_funct3,
           out_imm, out_store_data, out_pc, out_rd, out_rd_we, out_illegal
  );
endinterface

// File: rtl/id_ex_alu_issue.sv
// RV32I operand/control issue stage: decodes the ID instruction, selects ALU operands and holds the ID/EX register.
module id_ex_alu_issue #(
  parameter bit SHAMT_CHECK      = 1'b1,
  parameter bit FLUSH_KEEPS_DATA = 1'b0
) (
  input logic              clk,
  input logic              rst,
  id_ex_alu_issue_if.slave bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] CTL_ADD  = 4'b0000;
  localparam logic [3:0] CTL_SUB  = 4'b0010;
  localparam logic [3:0] CTL_AND  = 4'b0100;
  localparam logic [3:0] CTL_OR   = 4'b0101;
  localparam logic [3:0] CTL_XOR  = 4'b0110;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_SLT  = 4'b1001;
  localparam logic [3:0] CTL_SLL  = 4'b1100;
  localparam logic [3:0] CTL_SRL  = 4'b1101;
  localparam logic [3:0] CTL_SRA  = 4'b1110;

  localparam logic [2:0] KIND_ALU    = 3'd0;
  localparam logic [2:0] KIND_LOAD   = 3'd1;
  localparam logic [2:0] KIND_STORE  = 3'd2;
  localparam logic [2:0] KIND_BRANCH = 3'd3;
  localparam logic [2:0] KIND_JAL    = 3'd4;
  localparam logic [2:0] KIND_JALR   = 3'd5;
  localparam logic [2:0] KIND_UPPER  = 3'd6;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  ctl;
    logic [2:0]  kind;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_t;

  // alt selects sub (funct3 000) or sra (funct3 101); it has no effect on the other ops
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? CTL_SUB : CTL_ADD;
      3'b001:  alu_op = CTL_SLL;
      3'b010:  alu_op = CTL_SLT;
      3'b011:  alu_op = CTL_SLTU;
      3'b100:  alu_op = CTL_XOR;
      3'b101:  alu_op = alt ? CTL_SRA : CTL_SRL;
      3'b110:  alu_op = CTL_OR;
      default: alu_op = CTL_AND;
    endcase
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        shift_imm;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst      = bus.in_inst;
  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  issue_t dec;
  logic   legal;
  logic   writes;

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    writes = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.kind = KIND_ALU;
        dec.da   = bus.in_rs1;
        dec.db   = bus.in_rs2;
        dec.ctl  = alu_op(funct3, funct7[5]);
        writes   = 1'b1;
        legal    = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec.kind = KIND_ALU;
        dec.da   = bus.in_rs1;
        dec.imm  = imm_i;
        writes   = 1'b1;
        if (shift_imm) begin
          dec.db  = {27'b0, inst[24:20]};
          dec.ctl = alu_op(funct3, funct3[2] & inst[30]);
          if (SHAMT_CHECK)
            legal = (funct7 == 7'b0000000) || ((funct3 == 3'b101) && (funct7 == 7'b0100000));
        end else begin
          dec.db  = imm_i;
          dec.ctl = alu_op(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        dec.kind = KIND_LOAD;
        dec.da   = bus.in_rs1;
        dec.db   = imm_i;
        dec.imm  = imm_i;
        writes   = 1'b1;
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        dec.kind       = KIND_STORE;
        dec.da         = bus.in_rs1;
        dec.db         = imm_s;
        dec.imm        = imm_s;
        dec.store_data = bus.in_rs2;
        legal          = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      OPC_BRANCH: begin
        // EX resolves BEQ/BNE on the zero flag of a subtract, the rest on a set-less-than
        dec.kind = KIND_BRANCH;
        dec.da   = bus.in_rs1;
        dec.db   = bus.in_rs2;
        dec.imm  = imm_b;
        dec.ctl  = !funct3[2] ? CTL_SUB : (funct3[1] ? CTL_SLTU : CTL_SLT);
        legal    = (funct3[2:1] != 2'b01);
      end
      OPC_LUI: begin
        dec.kind = KIND_UPPER;
        dec.db   = imm_u;
        dec.imm  = imm_u;
        writes   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.kind = KIND_UPPER;
        dec.da   = bus.in_pc;
        dec.db   = imm_u;
        dec.imm  = imm_u;
        writes   = 1'b1;
      end
      OPC_JAL: begin
        dec.kind = KIND_JAL;
        dec.da   = bus.in_pc;
        dec.db   = 32'd4;
        dec.imm  = imm_j;
        writes   = 1'b1;
      end
      OPC_JALR: begin
        dec.kind = KIND_JALR;
        dec.da   = bus.in_pc;
        dec.db   = 32'd4;
        dec.imm  = imm_i;
        writes   = 1'b1;
        legal    = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    // an illegal instruction still flows down the pipe, but inert apart from its flag, pc and funct3
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      writes      = 1'b0;
    end
    dec.pc     = bus.in_pc;
    dec.funct3 = funct3;
    dec.rd     = writes ? inst[11:7] : 5'd0;
    dec.rd_we  = writes && (inst[11:7] != 5'd0);
  end

  // Handshake: a transfer happens on an edge where valid and ready are both high; the
  // stage is ready whenever its register is empty or EX is consuming it this cycle, and
  // a held instruction keeps every output bit-stable until EX takes it.
  issue_t held;
  logic   held_valid;

  assign bus.in_ready = ~held_valid | bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid <= 1'b0;
      held       <= '0;
    end else if (bus.flush) begin
      held_valid <= 1'b0;
      if (!FLUSH_KEEPS_DATA)
        held <= '0;
    end else if (bus.in_ready) begin
      held_valid <= bus.in_valid;
      if (bus.in_valid)
        held <= dec;
    end
  end

  assign bus.out_valid      = held_valid;
  assign bus.ALU_DA         = held.da;
  assign bus.ALU_DB         = held.db;
  assign bus.ALU_CTL        = held.ctl;
  assign bus.out_kind       = held.kind;
  assign bus.out_funct3     = held.funct3;
  assign bus.out_imm        = held.imm;
  assign bus.out_store_data = held.store_data;
  assign bus.out_pc         = held.pc;
  assign bus.out_rd         = held.rd;
  assign bus.out_rd_we      = held.rd_we;
  assign bus.out_illegal    = held.illegal;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: directed scenarios plus random traffic checked against an instruction-level model.
`timescale 1ns/1ps
module tb_id_ex_alu_issue;
  logic clk = 1'b0;
  logic rst;

  id_ex_alu_issue_if bus();

  id_ex_alu_issue #(.SHAMT_CHECK(1'b1), .FLUSH_KEEPS_DATA(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  ctl;
    logic [2:0]  kind;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  exp_t mon_e;

  // ALU code for each funct3 of the register/immediate arithmetic group, base (non-alternate) form
  localparam logic [3:0] CTL_TAB [8] = '{4'h0, 4'hC, 4'h9, 4'h8, 4'h6, 4'hD, 4'h5, 4'h4};
  localparam logic [6:0] OPC_TAB [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic ok, wr;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ii, is, ib, iu, ij;
    f3 = w[14:12];
    f7 = w[31:25];
    ii = 32'($signed(w[31:20]));
    is = 32'($signed({w[31:25], w[11:7]}));
    ib = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    iu = w & 32'hFFFFF000;
    ij = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    e  = '0;
    ok = 1'b1;
    wr = 1'b0;
    case (w[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.da = a; e.db = b; e.ctl = CTL_TAB[f3]; wr = 1'b1;
        if (f7 == 7'h20) e.ctl = (f3 == 3'd0) ? 4'h2 : 4'hE;
      end
      7'h13: begin
        e.da = a; e.imm = ii; e.ctl = CTL_TAB[f3]; wr = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.db = 32'(w[24:20]);
          ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
          if (f3 == 3'd5 && f7 == 7'h20) e.ctl = 4'hE;
        end else begin
          e.db = ii;
        end
      end
      7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.kind = 3'd1; e.da = a; e.db = ii; e.imm = ii; wr = 1'b1; end
      7'h23: begin ok = f3 <= 3'd2; e.kind = 3'd2; e.da = a; e.db = is; e.imm = is; e.sd = b; end
      7'h63: begin
        ok = !(f3 inside {3'd2, 3'd3});
        e.kind = 3'd3; e.da = a; e.db = b; e.imm = ib;
        case (f3)
          3'd0, 3'd1: e.ctl = 4'h2;
          3'd4, 3'd5: e.ctl = 4'h9;
          default:    e.ctl = 4'h8;
        endcase
      end
      7'h37: begin e.kind = 3'd6; e.db = iu; e.imm = iu; wr = 1'b1; end
      7'h17: begin e.kind = 3'd6; e.da = pc; e.db = iu; e.imm = iu; wr = 1'b1; end
      7'h6F: begin e.kind = 3'd4; e.da = pc; e.db = 32'd4; e.imm = ij; wr = 1'b1; end
      7'h67: begin ok = (f3 == 3'd0); e.kind = 3'd5; e.da = pc; e.db = 32'd4; e.imm = ii; wr = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.illegal = 1'b1;
      wr = 1'b0;
    end
    e.pc = pc;
    e.funct3 = f3;
    if (wr) e.rd = w[11:7];
    e.rd_we = wr && (w[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if (k < 9) begin
      w[6:0] = OPC_TAB[k];
      if (k <= 1) begin
        case ($urandom_range(0, 3))
          0, 1:    w[31:25] = 7'h00;
          2:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
    end else if ($urandom_range(0, 3) == 0) begin
      w = 32'h0;
    end
    return w;
  endfunction

  // Stimulus side: whatever the model says is accepted this cycle joins the expected queue.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.in_valid && !bus.flush && (bus.out_ready || exp_q.size() == 0))
      exp_q.push_back(model(bus.in_inst, bus.in_pc, bus.in_rs1, bus.in_rs2));
  end

  // Monitor: the head of the queue is what EX must see; it leaves on consumption or flush.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0 || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (bus.out_valid && exp_q.size() != 0) begin
        mon_e = exp_t'(exp_q[0]);
        chk("ALU_DA", bus.ALU_DA, mon_e.da);
        chk("ALU_DB", bus.ALU_DB, mon_e.db);
        chk("ALU_CTL", 32'(bus.ALU_CTL), 32'(mon_e.ctl));
        chk("out_kind", 32'(bus.out_kind), 32'(mon_e.kind));
        chk("out_funct3", 32'(bus.out_funct3), 32'(mon_e.funct3));
        chk("out_imm", bus.out_imm, mon_e.imm);
        chk("out_store_data", bus.out_store_data, mon_e.sd);
        chk("out_pc", bus.out_pc, mon_e.pc);
        chk("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
        chk("out_rd_we", 32'(bus.out_rd_we), 32'(mon_e.rd_we));
        chk("out_illegal", 32'(bus.out_illegal), 32'(mon_e.illegal));
        if (bus.out_ready || bus.flush) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the edge that loaded the instruction.
  task automatic issue(input logic [31:0] w, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, output int cyc);
    bus.in_inst  = w;
    bus.in_pc    = pc;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.in_ready && !bus.flush) && cyc < 50);
    if (cyc >= 50) chk("issue timeout", 32'(cyc), 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.out_ready = 1'b0;
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset ALU_CTL", 32'(bus.ALU_CTL), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset ALU_DA", bus.ALU_DA, 32'd0);
    chk("reset out_rd_we", 32'(bus.out_rd_we), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // ADDI x1,x2,-1
    issue(32'hFFF10093, 32'h0, 32'd5, 32'd0, n);
    @(negedge clk);
    chk("addi out_valid", 32'(bus.out_valid), 32'd1);
    chk("addi DA", bus.ALU_DA, 32'd5);
    chk("addi DB", bus.ALU_DB, 32'hFFFFFFFF);
    chk("addi CTL", 32'(bus.ALU_CTL), 32'h0);
    chk("addi rd", 32'(bus.out_rd), 32'd1);
    chk("addi rd_we", 32'(bus.out_rd_we), 32'd1);

    // SRAI x3,x4,4 and the same word with a bad shift funct7
    tick();
    issue(32'h40425193, 32'h4, 32'h80000000, 32'd0, n);
    @(negedge clk);
    chk("srai DA", bus.ALU_DA, 32'h80000000);
    chk("srai DB", bus.ALU_DB, 32'd4);
    chk("srai CTL", 32'(bus.ALU_CTL), 32'hE);
    chk("srai illegal", 32'(bus.out_illegal), 32'd0);
    tick();
    issue(32'h60425193, 32'h8, 32'h80000000, 32'd0, n);
    @(negedge clk);
    chk("bad shamt illegal", 32'(bus.out_illegal), 32'd1);
    chk("bad shamt rd_we", 32'(bus.out_rd_we), 32'd0);
    chk("bad shamt CTL", 32'(bus.ALU_CTL), 32'd0);

    // BLTU x1,x2,+8
    tick();
    issue(32'h0020E463, 32'hC, 32'd3, 32'd7, n);
    @(negedge clk);
    chk("bltu CTL", 32'(bus.ALU_CTL), 32'h8);
    chk("bltu DA", bus.ALU_DA, 32'd3);
    chk("bltu DB", bus.ALU_DB, 32'd7);
    chk("bltu kind", 32'(bus.out_kind), 32'd3);
    chk("bltu funct3", 32'(bus.out_funct3), 32'd6);
    chk("bltu imm", bus.out_imm, 32'd8);
    chk("bltu rd_we", 32'(bus.out_rd_we), 32'd0);

    // Stall: AUIPC held for three cycles while ID keeps offering ADDI x6,x0,7
    tick();
    bus.out_ready = 1'b0;
    issue(32'h00001297, 32'h100, 32'd0, 32'd0, n);
    bus.in_inst = 32'h00700313; bus.in_pc = 32'h104; bus.in_rs1 = 32'd0; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall DA", bus.ALU_DA, 32'h100);
      chk("stall DB", bus.ALU_DB, 32'h1000);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("after stall DA", bus.ALU_DA, 32'd0);
    chk("after stall DB", bus.ALU_DB, 32'd7);
    chk("after stall pc", bus.out_pc, 32'h104);

    // Flush with a held LUI and a new instruction arriving
    tick();
    bus.out_ready = 1'b0;
    issue(32'h123453B7, 32'h200, 32'd0, 32'd0, n);
    bus.in_inst = 32'hFFF10093; bus.in_rs1 = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush DA", bus.ALU_DA, 32'd0);
    chk("flush DB", bus.ALU_DB, 32'd0);
    chk("flush imm", bus.out_imm, 32'd0);
    chk("flush rd", 32'(bus.out_rd), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    issue(32'hFFF10093, 32'h204, 32'd9, 32'd0, n);
    @(negedge clk);
    chk("post flush out_valid", 32'(bus.out_valid), 32'd1);
    chk("post flush DA", bus.ALU_DA, 32'd9);

    // Flush together with in_valid and out_ready
    tick();
    bus.in_inst = 32'h00500113; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush+valid in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush+valid dropped", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a stall
    tick();
    bus.out_ready = 1'b0;
    issue(32'h010000EF, 32'h300, 32'd0, 32'd0, n);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid rst ALU_CTL", 32'(bus.ALU_CTL), 32'd0);
    chk("mid rst ALU_DA", bus.ALU_DA, 32'd0);
    chk("mid rst in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    issue(32'h00500113, 32'h400, 32'd0, 32'd0, n);
    chk("post rst accept cycles", 32'(n), 32'd1);
    @(negedge clk);
    chk("post rst out_valid", 32'(bus.out_valid), 32'd1);
    chk("post rst DB", bus.ALU_DB, 32'd5);

    // Random traffic
    repeat (2000) begin
      tick();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.in_inst   = gen_inst();
      bus.in_pc     = $urandom() & 32'hFFFFFFFC;
      bus.in_rs1    = $urandom();
      bus.in_rs2    = $urandom();
    end
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain queue empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
